// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Holds executed stores between the second load/store stage and the data
// cache. Stores are allocated in program order, committed in order by the
// ROB and drained in order to the cache write port. The buffer also answers
// the load/store unit's same-cycle store-to-load forwarding lookup.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   store_valid/address/data/microop/ticket
//                            allocation of one store per cycle
//   commit_valid             ROB commits the oldest uncommitted store
//   flush_valid              discard all uncommitted entries
//   frw_address/microop      load lookup request (combinational)
//   frw_data/valid/stall     lookup result: hit data, hit, partial overlap
//   cache_wr_ready           cache accepts the presented write
//   cache_writeback_valid    a write is presented (head entry committed)
//   cache_wr_addr/data/microop
//                            fields of the head entry
//   sb_full, sb_empty        registered occupancy flags
//
// Handshake: a write transfers on a rising edge where cache_writeback_valid
// and cache_wr_ready are both high. While valid is high and ready is low the
// presented address/data/microop hold steady; valid never depends on ready.
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 32,
    parameter int MICROOP    = 5,
    parameter int ROB_TICKET = 3,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  store_valid,
    input  logic [ADDR_BITS-1:0]  store_address,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [MICROOP-1:0]    store_microop,
    input  logic [ROB_TICKET-1:0] store_ticket,
    input  logic                  commit_valid,
    input  logic                  flush_valid,
    input  logic [ADDR_BITS-1:0]  frw_address,
    input  logic [MICROOP-1:0]    frw_microop,
    output logic [DATA_WIDTH-1:0] frw_data,
    output logic                  frw_valid,
    output logic                  frw_stall,
    input  logic                  cache_wr_ready,
    output logic                  cache_writeback_valid,
    output logic [ADDR_BITS-1:0]  cache_wr_addr,
    output logic [DATA_WIDTH-1:0] cache_wr_data,
    output logic [MICROOP-1:0]    cache_wr_microop,
    output logic                  sb_full,
    output logic                  sb_empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [MICROOP-1:0] OP_SW = MICROOP'(5'b00110);
    localparam logic [MICROOP-1:0] OP_SH = MICROOP'(5'b00111);
    localparam logic [MICROOP-1:0] OP_SB = MICROOP'(5'b01000);

    // Entry storage
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      committed_q;
    logic [ADDR_BITS-1:0]  addr_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q   [DEPTH];
    logic [MICROOP-1:0]    uop_q    [DEPTH];
    logic [ROB_TICKET-1:0] ticket_q [DEPTH];

    // Pointers carry one extra wrap bit above the index
    logic [PTR_W-1:0] head_q, cmt_q, tail_q;
    logic [IDX_W-1:0] head_idx, cmt_idx, tail_idx;
    logic [PTR_W-1:0] occupancy;

    logic do_alloc, do_commit, do_drain;
    logic [PTR_W-1:0] cmt_next;

    assign head_idx  = head_q[IDX_W-1:0];
    assign cmt_idx   = cmt_q[IDX_W-1:0];
    assign tail_idx  = tail_q[IDX_W-1:0];
    assign occupancy = tail_q - head_q;

    assign sb_full  = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign sb_empty = (head_q == tail_q);

    assign cache_writeback_valid = (head_q != cmt_q);
    assign cache_wr_addr         = addr_q[head_idx];
    assign cache_wr_data         = data_q[head_idx];
    assign cache_wr_microop      = uop_q[head_idx];

    // A flush discards any same-cycle allocation.
    assign do_alloc  = store_valid && !sb_full && !flush_valid;
    assign do_commit = commit_valid && (cmt_q != tail_q);
    assign do_drain  = cache_writeback_valid && cache_wr_ready;
    assign cmt_next  = do_commit ? cmt_q + PTR_W'(1) : cmt_q;

    // -------------------------------------------------------------------------
    // State update
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            cmt_q       <= '0;
            tail_q      <= '0;
            valid_q     <= '0;
            committed_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]   <= '0;
                data_q[i]   <= '0;
                uop_q[i]    <= '0;
                ticket_q[i] <= '0;
            end
        end else begin
            if (do_drain) begin
                head_q <= head_q + PTR_W'(1);
            end
            cmt_q <= cmt_next;
            // The same-cycle commit lands first, so the flushed tail sits
            // just past the entry that commit just claimed.
            if (flush_valid) begin
                tail_q <= cmt_next;
            end else if (do_alloc) begin
                tail_q <= tail_q + PTR_W'(1);
            end

            // Drained head entry is cleared so an empty buffer presents zeros.
            if (do_drain) begin
                valid_q[head_idx]     <= 1'b0;
                committed_q[head_idx] <= 1'b0;
                addr_q[head_idx]      <= '0;
                data_q[head_idx]      <= '0;
                uop_q[head_idx]       <= '0;
            end

            if (do_commit) begin
                committed_q[cmt_idx] <= 1'b1;
            end

            if (flush_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!committed_q[i] && !(do_commit && (cmt_idx == IDX_W'(i)))) begin
                        valid_q[i] <= 1'b0;
                    end
                end
            end

            if (do_alloc) begin
                valid_q[tail_idx]     <= 1'b1;
                committed_q[tail_idx] <= 1'b0;
                addr_q[tail_idx]      <= store_address;
                data_q[tail_idx]      <= store_data;
                uop_q[tail_idx]       <= store_microop;
                ticket_q[tail_idx]    <= store_ticket;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Forwarding lookup
    // -------------------------------------------------------------------------
    logic                  sel_found;
    logic [ADDR_BITS-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [MICROOP-1:0]    sel_uop;
    logic [PTR_W-1:0]      scan_ptr;
    logic [IDX_W-1:0]      scan_idx;
    logic                  frw_is_store;
    logic                  sel_hit;

    always_comb begin
        sel_found = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        sel_uop   = '0;
        scan_ptr  = '0;
        scan_idx  = '0;
        // Scan oldest to youngest so the youngest overlapping entry is the
        // last one written; i counts back from tail-1.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            scan_ptr = tail_q - PTR_W'(i + 1);
            scan_idx = scan_ptr[IDX_W-1:0];
            if ((PTR_W'(i) < occupancy) && valid_q[scan_idx] &&
                (addr_q[scan_idx][ADDR_BITS-1:2] == frw_address[ADDR_BITS-1:2])) begin
                sel_found = 1'b1;
                sel_addr  = addr_q[scan_idx];
                sel_data  = data_q[scan_idx];
                sel_uop   = uop_q[scan_idx];
            end
        end
        // Incoming store is younger than anything in the array.
        if (store_valid &&
            (store_address[ADDR_BITS-1:2] == frw_address[ADDR_BITS-1:2])) begin
            sel_found = 1'b1;
            sel_addr  = store_address;
            sel_data  = store_data;
            sel_uop   = store_microop;
        end
    end

    assign frw_is_store = (frw_microop == OP_SW) || (frw_microop == OP_SH) ||
                          (frw_microop == OP_SB);
    assign sel_hit      = sel_found && (sel_uop == OP_SW) && (sel_addr == frw_address);

    assign frw_valid = !rst && !frw_is_store && sel_hit;
    assign frw_stall = !rst && !frw_is_store && sel_found && !sel_hit;
    assign frw_data  = frw_valid ? sel_data : '0;

    // -------------------------------------------------------------------------
    // Protocol checks
    // -------------------------------------------------------------------------
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(store_valid && sb_full))
                else $error("store_buffer: store allocated while full, dropped");
            assert (!(commit_valid && (cmt_q == tail_q)))
                else $error("store_buffer: commit with no uncommitted entry, ignored");
            if (do_commit) begin
                assert (valid_q[cmt_idx] && !$isunknown(ticket_q[cmt_idx]))
                    else $error("store_buffer: committed entry invalid or ticket unknown");
            end
        end
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Holds executed stores between the load/store unit's second stage and the data cache. Stores are allocated in program order, committed in order by the ROB, and drained to the cache write port. The buffer answers the load/store unit's same-cycle store-to-load forwarding lookup. It also generates the `cache_writeback_valid` port-hazard signal that the load/store unit consumes.

## Interface
- `DATA_WIDTH`, 32, data bits
- `ADDR_BITS`, 32, address bits
- `MICROOP`, 5, micro-op bits
- `ROB_TICKET`, 3, ROB ticket bits
- `DEPTH`, 4, entries; must be a power of 2 and at least 2
- `clk` in 1: the single clock. All state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `store_valid` in 1: allocate a store this cycle.
- `store_address` in ADDR_BITS: byte address of the store.
- `store_data` in DATA_WIDTH: store data, right-aligned.
- `store_microop` in MICROOP: 00110 = SW, 00111 = SH, 01000 = SB.
- `store_ticket` in ROB_TICKET: ROB ticket of the store.
- `commit_valid` in 1: the ROB commits the oldest uncommitted store.
- `flush_valid` in 1: discard all uncommitted entries.
- `frw_address` in ADDR_BITS: load lookup address.
- `frw_microop` in MICROOP: load micro-op. Used only to qualify a lookup.
- `frw_data` out DATA_WIDTH: forwarded word.
- `frw_valid` out 1: forwarding hit.
- `frw_stall` out 1: partial overlap; the load must wait.
- `cache_wr_ready` in 1: the cache accepts a write.
- `cache_writeback_valid` out 1: a write is presented to the cache.
- `cache_wr_addr` out ADDR_BITS: write address.
- `cache_wr_data` out DATA_WIDTH: write data.
- `cache_wr_microop` out MICROOP: write micro-op.
- `sb_full` out 1: no free entry. Issue of stores must block.
- `sb_empty` out 1: no entries held.

## Operation
- Circular array of `DEPTH` entries. Each entry holds: valid, committed, address, data, microop, ticket.
- Pointers are log2(DEPTH)+1 bits wide. The MSB is the wrap bit.
  - `head`: oldest entry.
  - `cmt`: oldest uncommitted entry.
  - `tail`: next free entry.
- Occupancy is tail−head, modulo 2·DEPTH.
- Full means the low bits are equal and the wrap bits differ. Empty means head == tail.

Allocation:
- `store_valid` and not full: write the entry at `tail`, committed = 0, then increment `tail`.
- `store_valid` while full is a protocol error. The store is dropped and the pointers are unchanged. A simulation assertion fires.

Commit:
- `commit_valid` and cmt ≠ tail: set committed on entry `cmt`, then increment `cmt`.
- `commit_valid` with no uncommitted entry is ignored, with an assertion.

Drain:
- `cache_writeback_valid` = head ≠ cmt, i.e. the head entry is committed.
- The address, data and microop outputs present the head entry.
- On `cache_writeback_valid & cache_wr_ready`: clear the head entry, then increment `head`.

Flush:
- `tail` ← `cmt`. Uncommitted entries are invalidated.
- Committed entries keep draining.
- An allocation in the same cycle is discarded.
- A commit in the same cycle takes effect first: the entry at `cmt` becomes committed, and `tail` ← `cmt`+1.

Forwarding lookup (combinational):
- Candidates are all valid entries plus the incoming store when `store_valid` is high. The incoming store counts as the youngest candidate.
- A candidate overlaps when `address[ADDR_BITS-1:2]` == `frw_address[ADDR_BITS-1:2]`.
- The youngest overlapping candidate is selected by priority from tail−1 back toward head.
- Selected candidate is SW and its full address equals `frw_address`:
  - `frw_valid` = 1.
  - `frw_data` = the candidate's data.
  - `frw_stall` = 0.
- Selected candidate exists but does not meet that condition: `frw_stall` = 1 and `frw_valid` = 0.
- No overlap: both flags are 0 and `frw_data` = 0.
- If `frw_microop` is a store op, both flags are forced to 0.

Simultaneous events:
- Allocate, commit, drain and flush may all occur in one cycle. Each pointer is updated independently as described above.

## Timing
- During reset, and in the first cycle after it:
  - All entries are invalid and all pointers are 0.
  - `sb_empty` = 1.
  - `sb_full`, `cache_writeback_valid`, `frw_valid` and `frw_stall` are 0.
  - `frw_data`, `cache_wr_addr`, `cache_wr_data` and `cache_wr_microop` are 0.
- Reset overrides every other input in the same cycle.
- Allocated store: appears in the array at the next edge. It is forwardable in the same cycle through the bypass path.
- Commit to `cache_writeback_valid`: 1 cycle minimum.
- Drain throughput: 1 store per cycle while `cache_wr_ready` is held high.
- `sb_full` and `sb_empty` are registered-pointer functions. They do not reflect same-cycle allocate or drain.
- Forward outputs are combinational from registered state and the `store_*`/`frw_*` inputs. There is no path from `cache_wr_ready`.

## Test plan
- Reset, then SW at 0x100 with data 0xDEADBEEF. Next cycle, look up LW at 0x100 → `frw_valid` = 1, `frw_data` = 0xDEADBEEF.
- SB at 0x101, then look up LW at 0x100 → `frw_stall` = 1. Look up 0x104 → no hit.
- Same cycle: `store_valid` SW at 0x200 and lookup at 0x200 → bypass hit with the incoming data.
- DEPTH = 4:
  - Fill 4 stores → `sb_full` = 1.
  - Commit 2, then flush → tail = cmt = 2.
  - With `cache_wr_ready` = 1, exactly 2 writes are issued on consecutive cycles, then `sb_empty` = 1.
- `cache_wr_ready` held at 0 for 5 cycles with a committed head → `cache_writeback_valid` stays 1 and the outputs are stable. Releasing ready drains in order.
- Older SW at 0x300 with data 0x1, younger SW at 0x300 with data 0x2 → the lookup returns 0x2. Wrap the pointers twice and repeat → same result.
